// File: rtl/dac_update_sequencer.sv
// Sequences updates of a 4-channel DAC driver: shadow registers, round-robin service of
// dirty channels, enable/ready handshake, driver init after reset and timeout recovery.
module dac_update_sequencer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [1:0]       wr_ch,
    input  logic [11:0]      wr_data,
    input  logic             clr_err,
    output logic [3:0]       ch_pending,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] upd_count,
    output logic             dac_enable,
    output logic             dac_reset,
    input  logic             dac_ready,
    output logic [1:0]       address,
    output logic [11:0]      data
);

    typedef enum logic [2:0] {
        INIT_RST  = 3'd0,
        INIT_WAIT = 3'd1,
        IDLE      = 3'd2,
        ISSUE     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  timer_r;
    logic [1:0]  rr_last_r;
    logic [11:0] shadow_r [4];

    logic        exit_s;
    logic        in_wait_s;
    logic        in_flight_s;
    logic        timeout_s;
    logic [1:0]  sel_s;
    logic [3:0]  clr_mask_s;
    logic [3:0]  set_mask_s;
    logic [3:0]  pend_nxt_s;

    function automatic logic [3:0] onehot(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

    // Scan from farthest to nearest so the first dirty channel after 'last' wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (pend[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Wait-state exit, timeout detection, channel selection and next pending flags.
    always_comb begin
        exit_s = 1'b0;
        case (state_r)
            INIT_WAIT: exit_s = (timer_r >= 8'd2) && dac_ready;
            WAIT_ACK:  exit_s = !dac_ready;
            WAIT_DONE: exit_s = dac_ready;
            default:   exit_s = 1'b0;
        endcase
        in_wait_s   = (state_r == INIT_WAIT) || (state_r == WAIT_ACK) || (state_r == WAIT_DONE);
        in_flight_s = (state_r == WAIT_ACK) || (state_r == WAIT_DONE);
        timeout_s   = in_wait_s && !exit_s && (timer_r == TMAX);
        sel_s       = rr_pick(ch_pending, rr_last_r);
        clr_mask_s  = ((state_r == IDLE) && (ch_pending != 4'b0000)) ? onehot(sel_s) : 4'b0000;
        // A host write to the selected channel keeps it dirty; an aborted channel is re-queued.
        set_mask_s  = (wr_en ? onehot(wr_ch) : 4'b0000)
                    | ((timeout_s && in_flight_s) ? onehot(address) : 4'b0000);
        pend_nxt_s  = (ch_pending & ~clr_mask_s) | set_mask_s;
    end

    // Main sequencer FSM with registered driver and status outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= INIT_RST;
            timer_r     <= 8'd0;
            rr_last_r   <= 2'd3;
            shadow_r    <= '{default: 12'h000};
            ch_pending  <= 4'b0000;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            upd_count   <= '0;
            dac_enable  <= 1'b0;
            dac_reset   <= 1'b0;
            address     <= 2'd0;
            data        <= 12'h000;
        end else begin
            ch_pending <= pend_nxt_s;
            if (wr_en) begin
                shadow_r[wr_ch] <= wr_data;
            end
            dac_enable <= 1'b0;
            dac_reset  <= 1'b0;
            timer_r    <= timer_r + 8'd1;
            if (clr_err) begin
                err_timeout <= 1'b0;
            end
            if (timeout_s) begin
                err_timeout <= 1'b1;
                state_r     <= INIT_RST;
                busy        <= 1'b1;
            end else begin
                case (state_r)
                    INIT_RST: begin
                        dac_reset <= 1'b1;
                        timer_r   <= 8'd0;
                        state_r   <= INIT_WAIT;
                        busy      <= 1'b1;
                    end
                    INIT_WAIT: begin
                        if (exit_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    IDLE: begin
                        if (ch_pending != 4'b0000) begin
                            address   <= sel_s;
                            data      <= shadow_r[sel_s];
                            rr_last_r <= sel_s;
                            state_r   <= ISSUE;
                            busy      <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        dac_enable <= 1'b1;
                        timer_r    <= 8'd0;
                        state_r    <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (exit_s) begin
                            timer_r <= 8'd0;
                            state_r <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (exit_s) begin
                            upd_count <= upd_count + CNT_W'(1);
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= INIT_RST;
                        busy    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer with a simple DAC driver responder model.
module tb_dac_update_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = 2'd0;
    logic [11:0] wr_data = 12'h000;
    logic        clr_err = 1'b0;
    logic [3:0]  ch_pending;
    logic        busy;
    logic        err_timeout;
    logic [15:0] upd_count;
    logic        dac_enable;
    logic        dac_reset;
    logic        dac_ready;
    logic [1:0]  address;
    logic [11:0] data;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    dac_update_sequencer #(.TIMEOUT(256), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clr_err(clr_err), .ch_pending(ch_pending), .busy(busy), .err_timeout(err_timeout),
        .upd_count(upd_count), .dac_enable(dac_enable), .dac_reset(dac_reset),
        .dac_ready(dac_ready), .address(address), .data(data)
    );

    // Driver model: ready drops the edge after reset/enable, returns 3 cycles after reset
    // or 1 cycle after dropping for an update; 'stall' keeps it low.
    logic drv_ready = 1'b1;
    int   drv_cnt = 0;
    logic stall = 1'b0;
    assign dac_ready = drv_ready;
    always @(posedge CLK) begin
        if (dac_reset) begin
            drv_ready <= 1'b0;
            drv_cnt   <= 2;
        end else if (dac_enable) begin
            drv_ready <= 1'b0;
            drv_cnt   <= 1;
        end else if (drv_cnt == 1) begin
            if (!stall) begin
                drv_ready <= 1'b1;
                drv_cnt   <= 0;
            end
        end else if (drv_cnt > 1) begin
            drv_cnt <= drv_cnt - 1;
        end
    end

    // Monitor: record every update sent to the driver and pulse statistics.
    logic [13:0] sent[$];
    int   n_rst_pulse = 0;
    int   cyc = 0;
    int   last_en_cyc = -1000;
    int   min_gap = 1000;
    int   b2b = 0;
    logic prev_en = 1'b0;
    always @(negedge CLK) begin
        cyc++;
        if (dac_reset) n_rst_pulse++;
        if (dac_enable) begin
            sent.push_back({address, data});
            if (cyc - last_en_cyc < min_gap) min_gap = cyc - last_en_cyc;
            last_en_cyc = cyc;
            if (prev_en) b2b++;
        end
        prev_en = dac_enable;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [11:0] val);
        wr_en = 1'b1; wr_ch = ch; wr_data = val;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while ((busy !== 1'b0 || ch_pending !== 4'b0000) && k < 2000);
        chk(tag, (busy === 1'b0 && ch_pending === 4'b0000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_enable(input string tag);
        int k;
        k = 0;
        while (dac_enable !== 1'b1 && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, {31'd0, dac_enable}, 32'd1);
    endtask

    initial begin
        int k;
        int base;

        // 1: reset (with a write that must be dropped), release, driver init
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 12'h555;
        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_pending", {28'd0, ch_pending}, 32'd0);
        chk("rst_outs", {dac_enable, dac_reset, err_timeout, address, data}, 32'd0);
        chk("rst_count", {16'd0, upd_count}, 32'd0);
        wr_en = 1'b0;
        RST_N = 1'b1;
        wait_quiet("init_quiet", k);
        chk("init_cycles", k, 32'd5);
        chk("init_rst_pulses", n_rst_pulse, 32'd1);
        chk("init_count", {16'd0, upd_count}, 32'd0);

        // 2: single write ch2
        wr(2'd2, 12'hABC);
        wait_quiet("t2_quiet", k);
        chk("t2_latency", k, 32'd5);
        chk("t2_sent_n", sent.size(), 32'd1);
        chk("t2_sent0", {18'd0, sent[0]}, {18'd0, 2'd2, 12'hABC});
        chk("t2_hold", {18'd0, address, data}, {18'd0, 2'd2, 12'hABC});
        chk("t2_count", {16'd0, upd_count}, 32'd1);

        // 3: burst 0,1,3 then 3,2,0 -> order 0,1,3,3,0,2
        sent.delete();
        min_gap = 1000;
        wr(2'd0, 12'h0A1); wr(2'd1, 12'h1B2); wr(2'd3, 12'h3C3);
        wait_quiet("t3a_quiet", k);
        wr(2'd3, 12'h3D4); wr(2'd2, 12'h2E5); wr(2'd0, 12'h0F6);
        wait_quiet("t3b_quiet", k);
        chk("t3_sent_n", sent.size(), 32'd6);
        chk("t3_sent0", {18'd0, sent[0]}, {18'd0, 2'd0, 12'h0A1});
        chk("t3_sent1", {18'd0, sent[1]}, {18'd0, 2'd1, 12'h1B2});
        chk("t3_sent2", {18'd0, sent[2]}, {18'd0, 2'd3, 12'h3C3});
        chk("t3_sent3", {18'd0, sent[3]}, {18'd0, 2'd3, 12'h3D4});
        chk("t3_sent4", {18'd0, sent[4]}, {18'd0, 2'd0, 12'h0F6});
        chk("t3_sent5", {18'd0, sent[5]}, {18'd0, 2'd2, 12'h2E5});
        chk("t3_min_gap", min_gap, 32'd5);
        chk("t3_count", {16'd0, upd_count}, 32'd7);

        // 4: overwrite before selection, then overwrite in the select cycle
        sent.delete();
        wr(2'd3, 12'h3AA); wr(2'd1, 12'h100); wr(2'd1, 12'h200);
        wait_quiet("t4a_quiet", k);
        chk("t4a_sent_n", sent.size(), 32'd2);
        chk("t4a_sent0", {18'd0, sent[0]}, {18'd0, 2'd3, 12'h3AA});
        chk("t4a_sent1", {18'd0, sent[1]}, {18'd0, 2'd1, 12'h200});
        sent.delete();
        wr(2'd2, 12'h5A5); wr(2'd2, 12'h5A6);
        wait_quiet("t4b_quiet", k);
        chk("t4b_sent_n", sent.size(), 32'd2);
        chk("t4b_sent0", {18'd0, sent[0]}, {18'd0, 2'd2, 12'h5A5});
        chk("t4b_sent1", {18'd0, sent[1]}, {18'd0, 2'd2, 12'h5A6});
        chk("t4_count", {16'd0, upd_count}, 32'd11);

        // 5: stalled driver -> timeout, re-init, resend, clear error
        sent.delete();
        stall = 1'b1;
        base = n_rst_pulse;
        wr(2'd0, 12'h0F0);
        wait_enable("t5_enable");
        k = 0;
        while (err_timeout !== 1'b1 && k < 400) begin
            @(negedge CLK);
            k++;
        end
        chk("t5_err_set", {31'd0, err_timeout}, 32'd1);
        chk("t5_err_delay", k, 32'd258);
        chk("t5_requeued", {28'd0, ch_pending}, 32'd1);
        stall = 1'b0;
        repeat (2) @(negedge CLK);
        chk("t5_rst_pulse", n_rst_pulse - base, 32'd1);
        wait_quiet("t5_quiet", k);
        chk("t5_sent_n", sent.size(), 32'd2);
        chk("t5_resent", {18'd0, sent[1]}, {18'd0, 2'd0, 12'h0F0});
        chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
        chk("t5_count", {16'd0, upd_count}, 32'd12);
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        chk("t5_err_clr", {31'd0, err_timeout}, 32'd0);

        // 6: reset during WAIT_DONE
        sent.delete();
        stall = 1'b1;
        wr(2'd1, 12'h777); wr(2'd2, 12'h888);
        wait_enable("t6_enable");
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 12'h999;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd1);
        chk("t6_pending", {28'd0, ch_pending}, 32'd0);
        chk("t6_outs", {dac_enable, dac_reset, err_timeout, address, data}, 32'd0);
        chk("t6_count", {16'd0, upd_count}, 32'd0);
        stall = 1'b0;
        base = n_rst_pulse;
        sent.delete();
        RST_N = 1'b1;
        wait_quiet("t6_quiet", k);
        chk("t6_init_cycles", k, 32'd5);
        chk("t6_rst_pulse", n_rst_pulse - base, 32'd1);
        chk("t6_sent_n", sent.size(), 32'd1 - 32'd1);
        chk("no_b2b_enable", b2b, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
